sup_ram_mar_p: RTL
==================

Name: sup_ram_mar_p

Overview:
Parametrised memory-plus-address-register block for the SUP-1 family. It replaces the fixed 16x8 RAM/MAR and generalises data width and depth. It adds post-increment of the address register, a front-panel programming port, a hardware clear sequencer, and sticky conflict detection. It sits on the processor bus under control-word signals from the controller; top-level tri-stating of the shared bus is done outside the block using bus_oe.

Parameters:
DATA_W, 8, bus/word width in bits
ADDR_W, 4, address width in bits; DEPTH = 2**ADDR_W; must satisfy ADDR_W <= DATA_W
INIT_VAL, 0, value written to every word by the clear sequencer

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset
bus_in  in  DATA_W  value currently on processor bus
bus_out  out  DATA_W  word driven toward bus
bus_oe  out  1  bus drive enable for bus_out
mi  in  1  load MAR from bus_in[ADDR_W-1:0]
ri  in  1  write bus_in to mem[MAR]
ro  in  1  read mem[MAR] onto bus
mar_inc  in  1  post-increment MAR
clr_req  in  1  start clear sequence (one-cycle pulse sufficient)
prog_en  in  1  programming mode; processor controls ignored
prog_addr  in  ADDR_W  programming address
prog_data  in  DATA_W  programming data
prog_we  in  1  programming write strobe
mar_q  out  ADDR_W  current MAR value
ready  out  1  high when in IDLE
err  out  1  sticky conflict flag

Behaviour:
- Storage: DEPTH x DATA_W register array. Memory contents are not reset by rst; only the clear sequencer initialises them.
- FSM states: CLEAR and IDLE.
- Reset (rst=0, asynchronous):
  - mar_q=0, err=0, ready=0.
  - FSM=CLEAR, clear pointer=0.
  - bus_oe=0, bus_out=0.
- CLEAR:
  - Each posedge writes INIT_VAL to mem[ptr], then ptr++.
  - On the posedge that writes DEPTH-1, go to IDLE.
  - ready rises after exactly DEPTH posedges; a reset release to ready takes DEPTH cycles.
  - mi, ri, ro, mar_inc, prog_we and clr_req are ignored; bus_oe=0; MAR holds.
- IDLE, clr_req=1: go to CLEAR with ptr=0 on the next posedge. That posedge performs no other write; MAR holds.
- IDLE, prog_en=1 (processor controls ignored, bus_oe=0):
  - prog_we=1 writes prog_data to mem[prog_addr] at posedge.
  - MAR unchanged.
- IDLE, prog_en=0:
  - bus_oe = ro & ~ri.
  - bus_out = mem[mar_q], combinational read, zero latency within the cycle.
  - When bus_oe=0, bus_out=0.
  - ri & ~ro: mem[mar_q] <= bus_in at posedge, using the MAR value before any same-edge update.
  - ri & ro: no write, no drive, err <= 1.
  - mi: mar_q <= bus_in[ADDR_W-1:0] at posedge; upper bus bits ignored.
  - mar_inc & ~mi: mar_q <= mar_q+1, wrapping DEPTH-1 -> 0.
  - mi & mar_inc: mi wins, err unchanged.
  - ri with mar_inc in the same cycle: write uses the old address, then increment.
- err is cleared only by rst.
- Reset mid-CLEAR restarts the clear from address 0. Reset mid-write aborts the write; the partial word is don't-care.

Test Plan:
- Release reset with DATA_W=8, ADDR_W=4, INIT_VAL=8'hA5 -> ready low for 16 cycles, then high; ro at every MAR 0..15 reads 8'hA5.
- mi with bus_in=8'hF3 -> mar_q=3; ri with bus_in=8'h5C at the next edge -> ro shows 8'h5C, bus_oe=1.
- mar_q=15, mar_inc -> mar_q=0; ri+mar_inc at mar_q=7, bus_in=8'h11 -> mem[7]=8'h11, mar_q=8; mi+mar_inc with bus_in=2 -> mar_q=2.
- ri and ro together at mar_q=4 -> mem[4] unchanged, bus_oe=0, err=1 and held until rst.
- prog_en=1, prog_we writes 8'h3C to addr 9 while ro=1 and mi=1 -> bus_oe=0, mar_q unchanged; after prog_en=0 with MAR=9, ro reads 8'h3C.
- clr_req in IDLE, then rst pulsed low at clear cycle 5 -> ready stays low for 16 cycles after release and all words read INIT_VAL.

Source files
------------

// File: rtl/sup_ram_mar_p.sv
// SUP-1 memory plus address register: parametrised RAM with post-incrementing MAR,
// front-panel programming port, hardware clear sequencer and sticky ri/ro conflict flag.
module sup_ram_mar_p #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 4,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   input  logic              mi,
   input  logic              ri,
   input  logic              ro,
   input  logic              mar_inc,
   input  logic              clr_req,
   input  logic              prog_en,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_we,
   output logic [ADDR_W-1:0] mar_q,
   output logic              ready,
   output logic              err
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_mar;
   logic              r_err;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_memWe;
   logic [ADDR_W-1:0] w_memAddr;
   logic [DATA_W-1:0] w_memData;
   logic              w_oe;

   // Single write port shared by the clear sequencer, the programming port and the bus.
   always_comb begin
      w_memWe   = 1'b0;
      w_memAddr = r_mar;
      w_memData = bus_in;
      if (r_state == ST_CLEAR) begin
         w_memWe   = 1'b1;
         w_memAddr = r_ptr;
         w_memData = INIT_VAL;
      end else if (clr_req) begin
         w_memWe   = 1'b0;
      end else if (prog_en) begin
         w_memWe   = prog_we;
         w_memAddr = prog_addr;
         w_memData = prog_data;
      end else begin
         w_memWe   = ri & ~ro;
      end
   end

   // Storage is deliberately not reset; the clear sequencer is the only initialiser.
   always_ff @(posedge clk) begin
      if (w_memWe) begin
         r_mem[w_memAddr] <= w_memData;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_CLEAR;
         r_ptr   <= '0;
         r_mar   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_ptr <= r_ptr + 1'b1;
               if (r_ptr == '1) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (clr_req) begin
                  r_state <= ST_CLEAR;
                  r_ptr   <= '0;
               end else if (!prog_en) begin
                  if (ri && ro) begin
                     r_err <= 1'b1;
                  end
                  // A same-cycle load takes precedence over the increment.
                  if (mi) begin
                     r_mar <= bus_in[ADDR_W-1:0];
                  end else if (mar_inc) begin
                     r_mar <= r_mar + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_CLEAR;
               r_ptr   <= '0;
            end
         endcase
      end
   end

   assign w_oe    = (r_state == ST_IDLE) & ~prog_en & ro & ~ri;
   assign bus_oe  = w_oe;
   assign bus_out = w_oe ? r_mem[r_mar] : '0;
   assign mar_q   = r_mar;
   assign ready   = (r_state == ST_IDLE);
   assign err     = r_err;

endmodule
